// File: rtl/decode_stage.sv
// RV32I integer decode stage: decodes ALU-class instructions into an operation
// and two operands, held in a single-entry ready/valid output register.

typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
} alu_op_t;

module decode_stage #(
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    input  logic [31:0]          rs1_data,
    input  logic [31:0]          rs2_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output alu_op_t              out_op,
    output logic [31:0]          out_arg_1,
    output logic [31:0]          out_arg_2,
    output logic [4:0]           out_rd,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic        capture;

    alu_op_t     dec_op;
    logic [31:0] dec_arg_1;
    logic [31:0] dec_arg_2;
    logic        dec_illegal;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u    = {in_instr[31:12], 12'b0};
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    assign in_ready = rst_n && !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    // funct3 mapping shared by register and immediate forms; the alternate
    // funct7 encodings (SUB/SRA) are resolved by the caller.
    function automatic alu_op_t base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_op      = ALU_ADD;
        dec_arg_1   = '0;
        dec_arg_2   = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_arg_1 = rs1_data;
                dec_arg_2 = rs2_data;
                if (funct7 == 7'b0) begin
                    dec_op = base_op(funct3);
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                    dec_op = ALU_SUB;
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
                    dec_op = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_arg_1 = rs1_data;
                dec_arg_2 = imm_i;
                dec_op    = base_op(funct3);
                // Shifts reuse imm[11:5] as a funct7 and take a 5-bit shamt.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_arg_2 = {27'b0, in_instr[24:20]};
                    if (funct7 != 7'b0) begin
                        if (funct3 == 3'b101 && funct7 == FUNCT7_ALT) begin
                            dec_op = ALU_SRA;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                end
            end
            OPC_LUI: begin
                dec_arg_2 = imm_u;
            end
            OPC_AUIPC: begin
                dec_arg_1 = in_pc;
                dec_arg_2 = imm_u;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        if (dec_illegal) begin
            dec_op    = ALU_ADD;
            dec_arg_1 = '0;
            dec_arg_2 = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
            out_op      <= ALU_ADD;
            out_arg_1   <= '0;
            out_arg_2   <= '0;
            out_rd      <= '0;
            ill_count   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_illegal <= dec_illegal;
            out_op      <= dec_op;
            out_arg_1   <= dec_arg_1;
            out_arg_2   <= dec_arg_2;
            out_rd      <= in_instr[11:7];
            if (dec_illegal && ill_count != '1) begin
                ill_count <= ill_count + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected entries are queued when a capture
// is driven and compared while the DUT holds them on its output.

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    alu_op_t     out_op;
    logic [31:0] out_arg_1;
    logic [31:0] out_arg_2;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic [15:0] ill_count;

    logic        s_in_ready;
    logic [4:0]  s_rs1_addr;
    logic [4:0]  s_rs2_addr;
    logic        s_out_valid;
    alu_op_t     s_out_op;
    logic [31:0] s_out_arg_1;
    logic [31:0] s_out_arg_2;
    logic [4:0]  s_out_rd;
    logic        s_out_illegal;
    logic [1:0]  s_ill_count;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_arg_1(out_arg_1), .out_arg_2(out_arg_2), .out_rd(out_rd),
        .out_illegal(out_illegal), .ill_count(ill_count)
    );

    // Narrow-counter instance sharing all inputs, used for saturation.
    decode_stage #(.ILL_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_op(s_out_op),
        .out_arg_1(s_out_arg_1), .out_arg_2(s_out_arg_2), .out_rd(s_out_rd),
        .out_illegal(s_out_illegal), .ill_count(s_ill_count)
    );

    typedef struct {
        alu_op_t     op;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t exp_cur;
    logic m_valid;
    int   m_ill;
    int   checks;
    int   errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input alu_op_t op, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [4:0] rd, input logic ill);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        rs1_data = d1;
        rs2_data = d2;
        exp_cur  = '{op: op, a1: a1, a2: a2, rd: rd, ill: ill};
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_op"},  32'(out_op), 32'(ALU_ADD));
        check({tag, "_a1"},  out_arg_1, 32'h0);
        check({tag, "_a2"},  out_arg_2, 32'h0);
        check({tag, "_rd"},  32'(out_rd), 32'h0);
        check({tag, "_ill"}, 32'(out_illegal), 32'h0);
        check({tag, "_cnt"}, 32'(ill_count), 32'h0);
    endtask

    // One clock: compare at the falling edge, advance the model, then step
    // to just after the next rising edge.
    task automatic tick();
        logic m_ready;
        logic cap;
        @(negedge clk);
        m_ready = rst_n && !flush && (!m_valid || out_ready);
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("ill_count", 32'(ill_count), 32'(m_ill));
        check("ill_count_sat", 32'(s_ill_count), (m_ill > 3) ? 32'd3 : 32'(m_ill));
        if (m_valid && q.size() > 0) begin
            check("out_op", 32'(out_op), 32'(q[0].op));
            check("out_arg_1", out_arg_1, q[0].a1);
            check("out_arg_2", out_arg_2, q[0].a2);
            check("out_rd", 32'(out_rd), 32'(q[0].rd));
            check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
        end
        cap = in_valid && m_ready;
        if (!rst_n) begin
            q.delete();
            m_valid = 1'b0;
            m_ill   = 0;
        end else if (flush) begin
            if (m_valid) void'(q.pop_front());
            m_valid = 1'b0;
        end else begin
            if (m_valid && out_ready) begin
                void'(q.pop_front());
                m_valid = 1'b0;
            end
            if (cap) begin
                q.push_back(exp_cur);
                m_valid = 1'b1;
                if (exp_cur.ill) m_ill++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; m_valid = 1'b0; m_ill = 0;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
        exp_cur = '{op: ALU_ADD, a1: 32'h0, a2: 32'h0, rd: 5'd0, ill: 1'b0};

        // Reset with a valid input present: nothing may be captured.
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7, ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b0);
        @(posedge clk); #1;
        tick();
        check_reset_outs("reset");

        // Decode coverage with the consumer always ready.
        rst_n = 1'b1; out_ready = 1'b1;
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7, ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b0);
        #1;
        check("rs1_addr", 32'(rs1_addr), 32'd1);
        check("rs2_addr", 32'(rs2_addr), 32'd2);
        tick();
        drive(32'h40335293, 32'h0, 32'h80000000, 32'h0, ALU_SRA, 32'h80000000, 32'd3, 5'd5, 1'b0);
        tick();
        drive(32'hFFF00093, 32'h0, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b0);
        tick();
        drive(32'h123450B7, 32'h0, 32'hDEADBEEF, 32'h0, ALU_ADD, 32'h0, 32'h12345000, 5'd1, 1'b0);
        tick();
        drive(32'h00001117, 32'h100, 32'hDEADBEEF, 32'h0, ALU_ADD, 32'h100, 32'h1000, 5'd2, 1'b0);
        tick();
        drive(32'h40208233, 32'h0, 32'd20, 32'd6, ALU_SUB, 32'd20, 32'd6, 5'd4, 1'b0);
        tick();
        drive(32'h02208233, 32'h0, 32'd20, 32'd6, ALU_ADD, 32'h0, 32'h0, 5'd4, 1'b1);
        tick();
        drive(32'h40109093, 32'h0, 32'd20, 32'd6, ALU_ADD, 32'h0, 32'h0, 5'd1, 1'b1);
        tick();
        drive(32'h01F0D093, 32'h0, 32'h12345678, 32'h0, ALU_SRL, 32'h12345678, 32'd31, 5'd1, 1'b0);
        tick();
        drive(32'h8000B113, 32'h0, 32'd9, 32'h0, ALU_SLTU, 32'd9, 32'hFFFFF800, 5'd2, 1'b0);
        tick();
        drive(32'h0020F2B3, 32'h0, 32'hF0F0F0F0, 32'h0FF00FF0, ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd5, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();

        // Back-pressure for three cycles with the next input held, then stream.
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'd11, 32'd22, ALU_ADD, 32'd11, 32'd22, 5'd3, 1'b0);
        tick();
        drive(32'h40208233, 32'h0, 32'd9, 32'd4, ALU_SUB, 32'd9, 32'd4, 5'd4, 1'b0);
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        drive(32'h0020C333, 32'h0, 32'hAAAA5555, 32'hFFFF0000, ALU_XOR, 32'hAAAA5555, 32'hFFFF0000, 5'd6, 1'b0);
        tick();
        drive(32'h0020E3B3, 32'h0, 32'h00000F00, 32'h000000F0, ALU_OR, 32'h00000F00, 32'h000000F0, 5'd7, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();

        // Flush of a stalled entry, overriding a valid input and a ready consumer.
        out_ready = 1'b0;
        drive(32'h0020A433, 32'h0, 32'd1, 32'd2, ALU_SLT, 32'd1, 32'd2, 5'd8, 1'b0);
        tick();
        flush = 1'b1; out_ready = 1'b1;
        drive(32'h00000000, 32'h0, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();

        // Reset asserted while an entry is stalled.
        out_ready = 1'b0;
        drive(32'h002094B3, 32'h0, 32'd3, 32'd4, ALU_SLL, 32'd3, 32'd4, 5'd9, 1'b0);
        tick();
        rst_n = 1'b0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        check_reset_outs("mid_reset");
        tick();

        // Illegal instructions: counter 0 -> 1, then saturation of the 2-bit copy.
        out_ready = 1'b1;
        drive(32'h00000000, 32'h0, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b1);
        tick();
        drive(32'hFFFFFFFF, 32'h0, 32'h5, 32'h6, ALU_ADD, 32'h0, 32'h0, 5'd31, 1'b1);
        tick();
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("ill_count_final", 32'(ill_count), 32'd5);
        check("ill_count_sat_final", 32'(s_ill_count), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
